npu_circ_buf_ctrl: RTL
======================

// Module: npu_circ_buf_ctrl
// PURPOSE
// - Sequencer for one NPU weight/schedule circular buffer, e.g. the 8192x16 buffer.
// - LOAD phase: streams config words from the config interface into the buffer using write_en only.
// - RUN phase: replays the stored words once per start pulse using read_en only. The buffer's delayed
//   write-back keeps occupancy constant across passes.
// - Guarantees read_en and write_en are never high together, and that full/empty are never violated.
// PARAMETERS
// DATA_W  16    word width of buffer and config stream
// DEPTH   8192  buffer capacity in words
// CNT_W   14    counter width, = clog2(DEPTH+1); holds the values 0..DEPTH
// PORTS
// CLK          in   1       global 100 MHz clock; all logic on posedge
// npu_rst      in   1       synchronous, active-high reset (global reset || npu config change)
// cfg_valid    in   1       config word present on cfg_data
// cfg_data     in   DATA_W  config word
// cfg_last     in   1       qualifies cfg_valid: this is the final word of the load
// cfg_ready    out  1       block accepts cfg word this cycle (handshake = cfg_valid & cfg_ready)
// flush        in   1       one-cycle pulse: discard buffer contents, return to EMPTY
// start        in   1       one-cycle pulse: begin one replay pass
// cons_ready   in   1       consumer can take a word; low stalls reads
// buf_rst      out  1       buffer reset = npu_rst | flush_q
// buf_wr_en    out  1       buffer write_en
// buf_rd_en    out  1       buffer read_en
// buf_din      out  DATA_W  buffer data input; = cfg_data, combinational pass-through
// word_valid   out  1       buffer dout holds a valid replay word this cycle
// word_idx     out  CNT_W-1 index of the word flagged by word_valid (0..total-1)
// word_last    out  1       word_valid word is the last of the pass
// loaded       out  1       buffer holds a complete load (state READY/RUN/SETTLE)
// busy         out  1       state is RUN or SETTLE
// pass_done    out  1       one-cycle pulse after the final write-back of a pass
// err          out  1       one-cycle pulse on an illegal request (see below)
// BEHAVIOUR
// - Reset (npu_rst=1 at posedge): state=EMPTY; load_cnt, total and rd_cnt = 0; every registered output = 0.
//   buf_rst=1 while npu_rst=1.
// - States: EMPTY, LOAD, READY, RUN, SETTLE, FLUSH.
// - EMPTY/LOAD:
//   - cfg_ready = (load_cnt < DEPTH).
//   - buf_wr_en = cfg_valid & cfg_ready, combinational; load_cnt increments on each accept.
//   - First accept moves EMPTY->LOAD.
//   - Accept with cfg_last: total <= load_cnt+1, then ->READY.
//   - cfg_valid while load_cnt==DEPTH: word dropped, err pulses, state unchanged.
// - READY: cfg_ready=0. start -> RUN with rd_cnt=0. cfg_valid -> err; reload requires flush first.
// - RUN: buf_rd_en = cons_ready & (rd_cnt < total), combinational; rd_cnt increments on each read.
//   - The read of index total-1 moves RUN->SETTLE.
//   - cons_ready low: no read that cycle and no write-back; resumes without loss.
// - SETTLE: one cycle, lets the last delayed write-back land. Then ->READY, pass_done pulses.
//   No rd/wr in SETTLE.
// - Read latency: word_valid, word_idx and word_last are registered one cycle after buf_rd_en (FIFO dout
//   latency 1). word_last is set for idx total-1.
// - start outside READY: ignored, err pulses. start in the same cycle that SETTLE exits: ignored, err.
// - flush, any state: next cycle state=FLUSH, buf_rst=1 for exactly 1 cycle, counters cleared.
//   Then ->EMPTY. An in-flight pass is aborted with no pass_done, and word_valid is forced 0 from FLUSH on.
// - flush together with start or cfg_valid: flush wins; the other request is dropped with no err.
// - npu_rst takes priority over everything, any cycle.
// - Invariant checked by assertion: never (buf_wr_en & buf_rd_en); never buf_wr_en in RUN/SETTLE.
// STRUCTURE
// - Shared package npu_pkg: state encoding localparams (CBC_EMPTY..CBC_FLUSH, 3 bits), NPU_WORD_W=16,
//   NPU_CBUF_DEPTH=8192.
// - Single module; no sub-module. npu_circ_buf_large is instantiated beside it by the parent, not inside.
// TESTING
// - Load 4 words 0x1111,0x2222,0x3333,0x4444 (last on 4th) -> loaded=1, 4 wr_en pulses, total=4.
// - Then start, cons_ready=1 -> rd_en 4 cycles; word_valid idx 0..3 carrying 0x1111..0x4444;
//   word_last on idx 3; pass_done 2 cycles after last rd. A second start replays identical data.
// - Stall: cons_ready low for 3 cycles after idx 1 -> no rd_en for 3 cycles; sequence 0x3333,0x4444 resumes.
// - Full load: 8192 words with no cfg_last -> cfg_ready drops after the 8192nd accept; word 8193 gives err=1.
// - flush at idx 2 of a pass -> buf_rst 1 cycle, no pass_done, state EMPTY, cfg_ready=1; a reload works.
// - start in EMPTY, and cfg_valid in READY -> err pulse each; no rd_en/wr_en; state unchanged.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: word width, circular-buffer depth and the
// state encoding used by the circular-buffer sequencer.
package npu_pkg;

    localparam int NPU_WORD_W     = 16;
    localparam int NPU_CBUF_DEPTH = 8192;

    typedef enum logic [2:0] {
        CBC_EMPTY  = 3'd0,
        CBC_LOAD   = 3'd1,
        CBC_READY  = 3'd2,
        CBC_RUN    = 3'd3,
        CBC_SETTLE = 3'd4,
        CBC_FLUSH  = 3'd5
    } cbc_state_e;

endpackage

// File: rtl/npu_circ_buf_ctrl.sv
// Load/replay sequencer for one NPU circular buffer: streams config words in
// with write_en, then replays them once per start pulse with read_en.
module npu_circ_buf_ctrl
    import npu_pkg::*;
#(
    parameter int DATA_W = NPU_WORD_W,
    parameter int DEPTH  = NPU_CBUF_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              npu_rst,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_last,
    output logic              cfg_ready,
    input  logic              flush,
    input  logic              start,
    input  logic              cons_ready,
    output logic              buf_rst,
    output logic              buf_wr_en,
    output logic              buf_rd_en,
    output logic [DATA_W-1:0] buf_din,
    output logic              word_valid,
    output logic [CNT_W-2:0]  word_idx,
    output logic              word_last,
    output logic              loaded,
    output logic              busy,
    output logic              pass_done,
    output logic              err
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    cbc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              flush_q, flush_d;
    logic              word_valid_q, word_valid_d;
    logic [CNT_W-2:0]  word_idx_q, word_idx_d;
    logic              word_last_q, word_last_d;
    logic              pass_done_q, pass_done_d;
    logic              err_q, err_d;

    logic              req_ok;
    logic              in_load;
    logic              wr_accept;

    // Flush and reset both suppress any buffer access in the same cycle.
    always_comb begin
        req_ok    = !npu_rst && !flush;
        in_load   = (state_q == CBC_EMPTY) || (state_q == CBC_LOAD);
        cfg_ready = in_load && (load_cnt_q < DEPTH_C) && req_ok;
        wr_accept = cfg_valid && cfg_ready;
        buf_wr_en = wr_accept;
        buf_rd_en = (state_q == CBC_RUN) && cons_ready && (rd_cnt_q < total_q) && req_ok;
        buf_din   = cfg_data;
    end

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        total_d      = total_q;
        rd_cnt_d     = rd_cnt_q;
        flush_d      = flush;
        word_valid_d = buf_rd_en;
        word_idx_d   = rd_cnt_q[CNT_W-2:0];
        word_last_d  = buf_rd_en && (rd_cnt_q == total_q - ONE_C);
        pass_done_d  = 1'b0;
        err_d        = 1'b0;

        if (flush) begin
            state_d    = CBC_FLUSH;
            load_cnt_d = '0;
            total_d    = '0;
            rd_cnt_d   = '0;
        end else begin
            err_d = start && (state_q != CBC_READY);
            unique case (state_q)
                CBC_EMPTY, CBC_LOAD: begin
                    if (wr_accept) begin
                        load_cnt_d = load_cnt_q + ONE_C;
                        if (cfg_last) begin
                            total_d = load_cnt_q + ONE_C;
                            state_d = CBC_READY;
                        end else begin
                            state_d = CBC_LOAD;
                        end
                    end else if (cfg_valid) begin
                        err_d = 1'b1;
                    end
                end
                CBC_READY: begin
                    if (cfg_valid) err_d = 1'b1;
                    if (start) begin
                        state_d  = CBC_RUN;
                        rd_cnt_d = '0;
                    end
                end
                CBC_RUN: begin
                    if (cfg_valid) err_d = 1'b1;
                    if (buf_rd_en) begin
                        rd_cnt_d = rd_cnt_q + ONE_C;
                        if (rd_cnt_q == total_q - ONE_C) state_d = CBC_SETTLE;
                    end
                end
                CBC_SETTLE: begin
                    if (cfg_valid) err_d = 1'b1;
                    state_d     = CBC_READY;
                    pass_done_d = 1'b1;
                end
                CBC_FLUSH: begin
                    state_d = CBC_EMPTY;
                end
                default: begin
                    state_d = CBC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (npu_rst) begin
            state_q      <= CBC_EMPTY;
            load_cnt_q   <= '0;
            total_q      <= '0;
            rd_cnt_q     <= '0;
            flush_q      <= 1'b0;
            word_valid_q <= 1'b0;
            word_idx_q   <= '0;
            word_last_q  <= 1'b0;
            pass_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            total_q      <= total_d;
            rd_cnt_q     <= rd_cnt_d;
            flush_q      <= flush_d;
            word_valid_q <= word_valid_d;
            word_idx_q   <= word_idx_d;
            word_last_q  <= word_last_d;
            pass_done_q  <= pass_done_d;
            err_q        <= err_d;
        end
    end

    assign buf_rst    = npu_rst | flush_q;
    assign word_valid = word_valid_q;
    assign word_idx   = word_idx_q;
    assign word_last  = word_last_q;
    assign pass_done  = pass_done_q;
    assign err        = err_q;
    assign loaded     = (state_q == CBC_READY) || (state_q == CBC_RUN) || (state_q == CBC_SETTLE);
    assign busy       = (state_q == CBC_RUN) || (state_q == CBC_SETTLE);

    // The buffer must never see a write and a read together, nor a write while replaying.
    assert property (@(posedge CLK) !(buf_wr_en && buf_rd_en));
    assert property (@(posedge CLK) !(buf_wr_en && ((state_q == CBC_RUN) || (state_q == CBC_SETTLE))));

endmodule
